mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multi-cycle control FSM that sequences the npc core datapath.
- Consumes the per-instruction decode bundle (reg_write, mem_write, load, branch, valid) and emits one-cycle enables: ir_write, pc_write, rf_write.
- Drives the single shared memory port through a req/ready handshake for both instruction fetch and load/store.
- Sits between the decoder, the register file/PC/IR and the memory bridge.

Parameters:
- TO_CYCLES, 255: max cycles mem_req may wait for mem_ready before a bus error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TO_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoder recognised the instruction in IR.
- dec_reg_write  in  1  instruction writes rd.
- dec_mem_write  in  1  store.
- dec_load  in  1  load (write-data source is memory).
- dec_branch  in  3  000 none, 001 jal, 010 jalr, 1xx conditional branch.
- dec_ebreak  in  1  IR holds ebreak.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_ifetch  out  1  1 = address from PC, 0 = address from ALU result.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- ir_write  out  1  latch mem read data into IR.
- pc_write  out  1  load next-PC (PC+4 or branch/jump target, selected in datapath).
- rf_write  out  1  register-file write enable.
- halted  out  1  sticky stop indication.
- err  out  2  00 ok, 01 illegal instruction, 10 bus timeout.
- state  out  3  current FSM state for trace/difftest.

Behaviour:
- States: RESET(0), FETCH(1), DECODE(2), EXEC(3), MEM(4), WB(5), HALT(7).
- Reset values:
  - state=RESET; all enables, mem_req, mem_we, halted = 0; err=00; timeout count=0.
  - RESET → FETCH on the first cycle after rst deasserts.
- FETCH:
  - mem_req=1, mem_ifetch=1, mem_we=0.
  - On a cycle with mem_ready=1: ir_write=1 in that same cycle, then next state DECODE.
- DECODE (1 cycle, no outputs):
  - dec_ebreak → HALT, err=00.
  - else !dec_valid → HALT, err=01.
  - else → EXEC.
- EXEC (1 cycle):
  - dec_load | dec_mem_write → MEM.
  - else dec_reg_write → WB.
  - else (conditional branch, or a non-writing op) → FETCH with pc_write=1 in EXEC.
- MEM:
  - mem_req=1, mem_ifetch=0, mem_we=dec_mem_write.
  - On mem_ready: store → FETCH with pc_write=1 that cycle; load → WB.
- WB (1 cycle): rf_write=1, pc_write=1, → FETCH.
  - Covers ALU ops, lui/auipc, loads, and jal/jalr (link write plus jump in the same cycle).
- Handshake rules:
  - mem_req, mem_we and mem_ifetch stay stable while waiting for mem_ready.
  - The transfer completes in the cycle where mem_req & mem_ready are both 1.
  - mem_req falls the next cycle; there are no back-to-back requests from the same state.
  - mem_ready while mem_req=0 is ignored.
- Enable rules:
  - pc_write fires exactly once per retired instruction.
  - rf_write is never asserted for stores or conditional branches.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each waiting cycle.
  - If TO_CYCLES≠0 and count==TO_CYCLES with no ready → HALT, err=10.
  - A ready arriving on the same cycle as count==TO_CYCLES wins; the transfer completes.
- HALT: all enables 0, halted=1, err held; leaves only on rst.
- rst in any state, including mid-handshake: next cycle is RESET with all outputs 0. Any outstanding memory transfer is abandoned.
- Latency in cycles, excluding memory wait:
  - ALU op, jal/jalr: 4.
  - branch: 3.
  - store: 4.
  - load: 5.

Optional Feature:
- NPC_PERF_CNT_EN defined:
  - Adds outputs perf_cycle[63:0] (increments every non-RESET, non-HALT cycle) and perf_instret[63:0] (increments on each pc_write).
  - Both counters reset to 0 and freeze in HALT.
- Undefined: the outputs and counters are absent.

Decomposition:
- Shared package npc_pkg:
  - state encoding constants (ST_RESET..ST_HALT).
  - err codes.
  - branch-field constants BR_NONE/BR_JAL/BR_JALR.
- Sub-module mc_mem_timer: timeout counter with clear/enable/expire outputs, parameterised by TO_CYCLES and CNT_W.

Test Plan:
- addi, mem_ready tied 1 → states 1,2,3,5; ir_write at FETCH, rf_write and pc_write at WB cycle; 4 cycles.
- lw with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles, mem_ifetch=0, mem_we=0, WB follows; 8 cycles total.
- sw → MEM with mem_we=1; pc_write on the ready cycle; rf_write never asserted.
- beq (dec_branch=100) → pc_write in EXEC, no rf_write; 3 cycles. jal → rf_write and pc_write together in WB.
- dec_valid=0 → HALT, err=01, halted=1 sticky over 20 cycles. With TO_CYCLES=4 and mem_ready=0 in FETCH → HALT, err=10 after 5 req cycles.
- rst pulsed mid-MEM wait → next cycle state=0, mem_req=0, then FETCH. With NPC_PERF_CNT_EN, perf_instret=3 after three retired addi.

Source files
------------

// File: rtl/npc_pkg.sv
// ============================================================================
// Module      : npc_pkg
// Description : Shared sequencer encodings: FSM states, error codes, branch field.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package npc_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;

    // Only plain ops and jumps may write rd; conditional branches never do.
    function automatic logic br_allows_rd_write(input logic [2:0] br);
        return (br == BR_NONE) || (br == BR_JAL) || (br == BR_JALR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_mem_timer.sv
// ============================================================================
// Module      : mc_mem_timer
// Description : Memory-handshake wait counter; expire flags count == TO_CYCLES.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_mem_timer #(
    parameter int TO_CYCLES = 255,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TO_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

    generate
        if (TO_CYCLES == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            assign expire = (count == LIMIT);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_sequencer.sv
// ============================================================================
// Module      : mc_sequencer
// Description : Multi-cycle control FSM for the npc core (fetch/decode/exec/
//               mem/wb). Define NPC_PERF_CNT_EN to add cycle/instret counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_sequencer
    import npc_pkg::*;
#(
    parameter int TO_CYCLES = 255,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic        dec_reg_write,
    input  logic        dec_mem_write,
    input  logic        dec_load,
    input  logic [2:0]  dec_branch,
    input  logic        dec_ebreak,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        rf_write,
    output logic        halted,
    output logic [1:0]  err,
    output logic [2:0]  state
`ifdef NPC_PERF_CNT_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`endif
);

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] err_q;
    logic [1:0] err_d;
    logic       tmr_clear;
    logic       tmr_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_RESET;
            err_q     <= ERR_OK;
        end else begin
            cur_state <= nxt_state;
            err_q     <= err_d;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        err_d      = err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        rf_write   = 1'b0;
        halted     = 1'b0;
        case (cur_state)
            ST_RESET: nxt_state = ST_FETCH;
            ST_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    nxt_state = ST_DECODE;
                end else if (tmr_expire) begin
                    nxt_state = ST_HALT;
                    err_d     = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_ebreak) begin
                    nxt_state = ST_HALT;
                    err_d     = ERR_OK;
                end else if (!dec_valid) begin
                    nxt_state = ST_HALT;
                    err_d     = ERR_ILLEGAL;
                end else begin
                    nxt_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_load || dec_mem_write) begin
                    nxt_state = ST_MEM;
                end else if (dec_reg_write && br_allows_rd_write(dec_branch)) begin
                    nxt_state = ST_WB;
                end else begin
                    pc_write  = 1'b1;
                    nxt_state = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_mem_write;
                if (mem_ready) begin
                    // Stores retire here; loads still need the write-back cycle.
                    if (dec_mem_write) begin
                        pc_write  = 1'b1;
                        nxt_state = ST_FETCH;
                    end else begin
                        nxt_state = ST_WB;
                    end
                end else if (tmr_expire) begin
                    nxt_state = ST_HALT;
                    err_d     = ERR_TIMEOUT;
                end
            end
            ST_WB: begin
                rf_write  = 1'b1;
                pc_write  = 1'b1;
                nxt_state = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: nxt_state = ST_RESET;
        endcase
    end

    assign state = cur_state;
    assign err   = err_q;

    // Restart the wait count whenever no request is pending or one just completed.
    assign tmr_clear = !((cur_state == ST_FETCH) || (cur_state == ST_MEM))
                       || (mem_req && mem_ready);

    mc_mem_timer #(
        .TO_CYCLES (TO_CYCLES),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (mem_req && !mem_ready),
        .expire (tmr_expire)
    );

`ifdef NPC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if ((cur_state != ST_RESET) && (cur_state != ST_HALT)) begin
                perf_cycle <= perf_cycle + 64'd1;
            end
            if (pc_write) begin
                perf_instret <= perf_instret + 64'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_sequencer.sv
// ============================================================================
// Module      : tb_mc_sequencer
// Description : Self-checking bench for mc_sequencer using per-instruction
//               expected-cycle traces. Honours NPC_PERF_CNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mc_sequencer;
    import npc_pkg::*;

    localparam int TO = 4;

    localparam int C_ALU  = 0;
    localparam int C_JAL  = 1;
    localparam int C_JALR = 2;
    localparam int C_BR   = 3;
    localparam int C_LD   = 4;
    localparam int C_ST   = 5;
    localparam int C_NOP  = 6;
    localparam int C_EBRK = 7;
    localparam int C_ILL  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid = 1'b0;
    logic       dec_reg_write = 1'b0;
    logic       dec_mem_write = 1'b0;
    logic       dec_load = 1'b0;
    logic [2:0] dec_branch = 3'b000;
    logic       dec_ebreak = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_ifetch, ir_write, pc_write, rf_write, halted;
    logic [1:0] err;
    logic [2:0] state;
`ifdef NPC_PERF_CNT_EN
    logic [63:0] perf_cycle, perf_instret;
    longint unsigned m_cyc = 0;
    longint unsigned m_ret = 0;
`endif

    always #5 clk = ~clk;

    mc_sequencer #(.TO_CYCLES(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid     (dec_valid),
        .dec_reg_write (dec_reg_write),
        .dec_mem_write (dec_mem_write),
        .dec_load      (dec_load),
        .dec_branch    (dec_branch),
        .dec_ebreak    (dec_ebreak),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_ifetch    (mem_ifetch),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .rf_write      (rf_write),
        .halted        (halted),
        .err           (err),
        .state         (state)
`ifdef NPC_PERF_CNT_EN
        ,
        .perf_cycle    (perf_cycle),
        .perf_instret  (perf_instret)
`endif
    );

    // One expected cycle: outputs the DUT must show, plus the mem_ready to drive.
    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       ifc;
        logic       irw;
        logic       pcw;
        logic       rfw;
        logic       hlt;
        logic [1:0] e;
        logic       rdy;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic       ins_valid, ins_rw, ins_mw, ins_ld, ins_eb;
    logic [2:0] ins_br;

    function automatic rec_t mk(input logic [2:0] st, input logic req, input logic we,
                                input logic ifc, input logic irw, input logic pcw,
                                input logic rfw, input logic hlt, input logic [1:0] e,
                                input logic rdy);
        rec_t r;
        r = '{st: st, req: req, we: we, ifc: ifc, irw: irw, pcw: pcw, rfw: rfw,
              hlt: hlt, e: e, rdy: rdy};
        return r;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_decode(input int cls);
        ins_valid = 1'b1; ins_rw = 1'b0; ins_mw = 1'b0; ins_ld = 1'b0;
        ins_eb = 1'b0; ins_br = BR_NONE;
        case (cls)
            C_ALU:  ins_rw = 1'b1;
            C_JAL:  begin ins_rw = 1'b1; ins_br = BR_JAL;  end
            C_JALR: begin ins_rw = 1'b1; ins_br = BR_JALR; end
            C_BR:   ins_br = 3'b100 | 3'($urandom_range(0, 3));
            C_LD:   begin ins_ld = 1'b1; ins_rw = 1'b1; end
            C_ST:   ins_mw = 1'b1;
            C_EBRK: ins_eb = 1'b1;
            C_ILL:  begin ins_valid = 1'b0; ins_rw = rbit(); end
            default: ;
        endcase
    endtask

    task automatic push_halt(input logic [1:0] e, input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(ST_HALT, 0, 0, 0, 0, 0, 0, 1, e, rbit()));
    endtask

    // Expected trace of one instruction; fw/mw are wait cycles before ready (> TO times out).
    task automatic build(input int cls, input int fw, input int mw);
        logic st;
        set_decode(cls);
        for (int i = 0; i < fw && i <= TO; i++) q.push_back(mk(ST_FETCH, 1, 0, 1, 0, 0, 0, 0, ERR_OK, 0));
        if (fw > TO) begin push_halt(ERR_TIMEOUT, 20); return; end
        q.push_back(mk(ST_FETCH, 1, 0, 1, 1, 0, 0, 0, ERR_OK, 1));
        q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, ERR_OK, rbit()));
        if (cls == C_EBRK) begin push_halt(ERR_OK, 20); return; end
        if (cls == C_ILL)  begin push_halt(ERR_ILLEGAL, 20); return; end
        q.push_back(mk(ST_EXEC, 0, 0, 0, 0, (cls == C_BR || cls == C_NOP), 0, 0, ERR_OK, rbit()));
        if (cls == C_LD || cls == C_ST) begin
            st = (cls == C_ST);
            for (int i = 0; i < mw && i <= TO; i++) q.push_back(mk(ST_MEM, 1, st, 0, 0, 0, 0, 0, ERR_OK, 0));
            if (mw > TO) begin push_halt(ERR_TIMEOUT, 20); return; end
            q.push_back(mk(ST_MEM, 1, st, 0, 0, st, 0, 0, ERR_OK, 1));
        end
        if (cls == C_ALU || cls == C_JAL || cls == C_JALR || cls == C_LD)
            q.push_back(mk(ST_WB, 0, 0, 0, 0, 1, 1, 0, ERR_OK, rbit()));
    endtask

    task automatic run_rec(input rec_t r);
        logic [11:0] act, exp;
        @(negedge clk);
        dec_valid = ins_valid; dec_reg_write = ins_rw; dec_mem_write = ins_mw;
        dec_load = ins_ld; dec_branch = ins_br; dec_ebreak = ins_eb;
        mem_ready = r.rdy;
        #1;
        act = {state, mem_req, mem_we, mem_ifetch, ir_write, pc_write, rf_write, halted, err};
        exp = {r.st, r.req, r.we, r.ifc, r.irw, r.pcw, r.rfw, r.hlt, r.e};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle t=%0t {st,req,we,ifc,irw,pcw,rfw,hlt,err} got %b expected %b",
                     $time, act, exp);
        end
`ifdef NPC_PERF_CNT_EN
        check_int("perf_cycle", longint'(perf_cycle), longint'(m_cyc));
        check_int("perf_instret", longint'(perf_instret), longint'(m_ret));
        if (r.st != ST_RESET && r.st != ST_HALT) m_cyc++;
        if (r.pcw) m_ret++;
`endif
        @(posedge clk);
    endtask

    task automatic run_q();
        while (q.size() > 0) run_rec(q.pop_front());
    endtask

    task automatic do_reset();
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = rbit();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = rbit();
        #1;
        check_int("reset_outputs",
                  longint'({state, mem_req, mem_we, mem_ifetch, ir_write, pc_write, rf_write, halted, err}),
                  0);
`ifdef NPC_PERF_CNT_EN
        check_int("reset_perf", longint'(perf_cycle | perf_instret), 0);
        m_cyc = 0;
        m_ret = 0;
`endif
        @(posedge clk);
    endtask

    function automatic int count_state(input logic [2:0] st);
        int n = 0;
        foreach (q[i]) if (q[i].st == st && q[i].req) n++;
        return n;
    endfunction

    initial begin
        do_reset();

        build(C_ALU, 0, 0);  check_int("len_addi", q.size(), 4);  run_q();
        build(C_LD, 0, 3);   check_int("len_lw_wait3", q.size(), 8);
        check_int("lw_req_cycles", count_state(ST_MEM), 4);       run_q();
        build(C_ST, 0, 0);   check_int("len_sw", q.size(), 4);    run_q();
        build(C_ST, 1, 2);   run_q();
        build(C_BR, 0, 0);   check_int("len_beq", q.size(), 3);   run_q();
        build(C_JAL, 0, 0);  check_int("len_jal", q.size(), 4);   run_q();
        build(C_JALR, 2, 0); run_q();
        build(C_LD, 0, 0);   check_int("len_lw", q.size(), 5);    run_q();
        build(C_NOP, 0, 0);  run_q();
        build(C_LD, TO, TO); run_q();
        build(C_ST, TO, TO); run_q();

        for (int n = 0; n < 80; n++) begin
            build($urandom_range(0, 6), $urandom_range(0, TO), $urandom_range(0, TO));
            run_q();
        end

`ifdef NPC_PERF_CNT_EN
        do_reset();
        for (int n = 0; n < 3; n++) begin build(C_ALU, 0, 0); run_q(); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_int("instret_after_3_addi", longint'(perf_instret), 3);
        @(posedge clk);
`endif

        do_reset();
        build(C_LD, 0, TO);
        for (int n = 0; n < 5; n++) run_rec(q.pop_front());
        do_reset();
        build(C_ALU, 1, 0); run_q();

        build(C_ILL, 0, 0); run_q(); do_reset();
        build(C_EBRK, 0, 0); run_q(); do_reset();
        build(C_ALU, TO + 1, 0);
        check_int("fetch_timeout_req_cycles", count_state(ST_FETCH), 5);
        run_q(); do_reset();
        build(C_ST, 0, TO + 1); run_q(); do_reset();
        build(C_ALU, 0, 0); run_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
